// File: rtl/ccm_pkg.sv
// Shared definitions for the CCM counter-mode stream datapath.
package ccm_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    KS   = 2'd2
  } ccm_state_e;

  // Plain-vector copies of the state encoding for the FSM register.
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_REQ  = REQ;
  localparam logic [1:0] ST_KS   = KS;

  // Fields must tile one AES block exactly, and beats must tile it in whole bytes.
  function automatic bit widths_ok(input int data_w, input int w_flag,
                                   input int w_nonce, input int w_count);
    if (data_w <= 0) return 1'b0;
    if ((data_w % 8) != 0) return 1'b0;
    if ((AES_BLOCK_W % data_w) != 0) return 1'b0;
    return (w_flag + w_nonce + w_count) == AES_BLOCK_W;
  endfunction

endpackage

// File: rtl/ccm_ctr_stream_if.sv
// Bundle of the control, stream and AES-port signals of ccm_ctr_stream.
interface ccm_ctr_stream_if #(
  parameter int DATA_W      = 32,
  parameter int WIDTH_NONCE = 100,
  parameter int WIDTH_FLAG  = 8,
  parameter int WIDTH_COUNT = 20
);
  localparam int KEEP_W = DATA_W / 8;

  logic                   start;
  logic [WIDTH_NONCE-1:0] ccm_ctr_nonce;
  logic [WIDTH_FLAG-1:0]  ccm_ctr_flag;
  logic [WIDTH_COUNT-1:0] count_init;

  logic [DATA_W-1:0]      input_data;
  logic                   input_en;
  logic                   input_last;
  logic [KEEP_W-1:0]      input_keep;
  logic                   input_ready;

  logic                   aes_req;
  logic [127:0]           aes_block;
  logic                   aes_ack;
  logic [127:0]           aes_result;

  logic [DATA_W-1:0]      out_data;
  logic                   out_en;
  logic                   out_last;
  logic [KEEP_W-1:0]      out_keep;
  logic                   out_ready;

  logic                   ctr_wrap;
  logic                   busy;

  // Datapath side
  modport slave (
    input  start, ccm_ctr_nonce, ccm_ctr_flag, count_init,
    input  input_data, input_en, input_last, input_keep,
    output input_ready,
    output aes_req, aes_block,
    input  aes_ack, aes_result,
    output out_data, out_en, out_last, out_keep,
    input  out_ready,
    output ctr_wrap, busy
  );

  // Environment side: packer, AES core and tag path
  modport master (
    output start, ccm_ctr_nonce, ccm_ctr_flag, count_init,
    output input_data, input_en, input_last, input_keep,
    input  input_ready,
    input  aes_req, aes_block,
    output aes_ack, aes_result,
    input  out_data, out_en, out_last, out_keep,
    output out_ready,
    input  ctr_wrap, busy
  );

endinterface

// File: rtl/ccm_ctr_ks_slicer.sv
// Holds one keystream block, tracks the beat index within it and produces the
// XORed, byte-masked beat plus its keep vector.
module ccm_ctr_ks_slicer
  import ccm_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   kill_n,
  input  logic                   i_clear,
  input  logic                   i_load,
  input  logic [AES_BLOCK_W-1:0] i_ks,
  input  logic                   i_beat,
  input  logic [DATA_W-1:0]      i_data,
  input  logic                   i_last,
  input  logic [DATA_W/8-1:0]    i_keep,
  output logic [DATA_W-1:0]      o_data,
  output logic [DATA_W/8-1:0]    o_keep,
  output logic                   o_block_end
);

  localparam int BEATS  = AES_BLOCK_W / DATA_W;
  localparam int KEEP_W = DATA_W / 8;
  localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  logic [AES_BLOCK_W-1:0] r_ks;
  logic [IDX_W-1:0]       r_idx;
  logic [AES_BLOCK_W-1:0] w_ks_shift;
  logic [DATA_W-1:0]      w_ks_beat;
  logic [DATA_W-1:0]      w_mask;

  // Keystream block register and beat index; a new block restarts at beat 0.
  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      r_ks  <= '0;
      r_idx <= '0;
    end else if (i_clear) begin
      r_ks  <= '0;
      r_idx <= '0;
    end else if (i_load) begin
      r_ks  <= i_ks;
      r_idx <= '0;
    end else if (i_beat) begin
      r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
    end
  end

  // Beat k uses the k-th DATA_W slice counted from the MSB end of the block.
  assign w_ks_shift  = r_ks << (DATA_W * int'(r_idx));
  assign w_ks_beat   = w_ks_shift[AES_BLOCK_W-1 -: DATA_W];
  assign o_block_end = (r_idx == LAST_IDX);
  assign o_keep      = i_last ? i_keep : {KEEP_W{1'b1}};

  // Expand keep to a bit mask so invalid bytes of the final beat read as zero.
  always_comb begin
    w_mask = '0;
    for (int b = 0; b < KEEP_W; b++) begin
      w_mask[b*8 +: 8] = {8{o_keep[b]}};
    end
  end

  assign o_data = (i_data ^ w_ks_beat) & w_mask;

endmodule

// File: rtl/ccm_ctr_stream.sv
// CCM counter-mode datapath: builds {flag,nonce,count} blocks for the AES core,
// XORs the returned keystream onto the stream and masks the final partial beat.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | no message; stream input blocked
//   REQ     | counter block offered on aes_req, waiting for aes_ack
//   KS      | keystream held; beats accepted and XORed until block/message end
module ccm_ctr_stream
  import ccm_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int WIDTH_NONCE = 100,
  parameter int WIDTH_FLAG  = 8,
  parameter int WIDTH_COUNT = 20
) (
  input logic             clk,
  input logic             kill_n,
  ccm_ctr_stream_if.slave bus
);

  localparam int KEEP_W = DATA_W / 8;

  if (!widths_ok(DATA_W, WIDTH_FLAG, WIDTH_NONCE, WIDTH_COUNT)) begin : g_bad_cfg
    $error("ccm_ctr_stream: fields must sum to 128 and DATA_W must be a byte multiple dividing 128");
  end

  logic [1:0]             r_state;
  logic                   r_aes_req;
  logic [WIDTH_FLAG-1:0]  r_flag;
  logic [WIDTH_NONCE-1:0] r_nonce;
  logic [WIDTH_COUNT-1:0] r_count;
  logic                   r_wrap;

  logic [DATA_W-1:0]      r_out_data;
  logic                   r_out_en;
  logic                   r_out_last;
  logic [KEEP_W-1:0]      r_out_keep;

  logic                   w_ack_take;
  logic                   w_beat;
  logic                   w_block_end;
  logic [DATA_W-1:0]      w_beat_data;
  logic [KEEP_W-1:0]      w_beat_keep;

  // An ack only counts while the request is actually raised; start beats everything.
  assign w_ack_take      = (r_state == ST_REQ) && r_aes_req && bus.aes_ack && !bus.start;
  assign bus.input_ready = (r_state == ST_KS) && !bus.start && (!r_out_en || bus.out_ready);
  assign w_beat          = bus.input_en && bus.input_ready;

  // Sequencing and counter fields. A start while a request is raised drops
  // aes_req for one cycle so the AES side sees a fresh request with new fields.
  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      r_state   <= ST_IDLE;
      r_aes_req <= 1'b0;
      r_flag    <= '0;
      r_nonce   <= '0;
      r_count   <= '0;
      r_wrap    <= 1'b0;
    end else if (bus.start) begin
      r_state   <= ST_REQ;
      r_aes_req <= !r_aes_req;
      r_flag    <= bus.ccm_ctr_flag;
      r_nonce   <= bus.ccm_ctr_nonce;
      r_count   <= bus.count_init;
      r_wrap    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_aes_req <= 1'b0;
        end
        ST_REQ: begin
          if (!r_aes_req) begin
            r_aes_req <= 1'b1;
          end else if (w_ack_take) begin
            r_aes_req <= 1'b0;
            r_state   <= ST_KS;
          end
        end
        ST_KS: begin
          if (w_beat) begin
            if (bus.input_last) begin
              r_state <= ST_IDLE;
            end else if (w_block_end) begin
              r_state   <= ST_REQ;
              r_aes_req <= 1'b1;
              r_count   <= r_count + WIDTH_COUNT'(1);
              if (&r_count) r_wrap <= 1'b1;
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_aes_req <= 1'b0;
        end
      endcase
    end
  end

  ccm_ctr_ks_slicer #(
    .DATA_W(DATA_W)
  ) u_slicer (
    .clk        (clk),
    .kill_n     (kill_n),
    .i_clear    (bus.start),
    .i_load     (w_ack_take),
    .i_ks       (bus.aes_result),
    .i_beat     (w_beat),
    .i_data     (bus.input_data),
    .i_last     (bus.input_last),
    .i_keep     (bus.input_keep),
    .o_data     (w_beat_data),
    .o_keep     (w_beat_keep),
    .o_block_end(w_block_end)
  );

  // Output register: loads on every accepted beat, holds while downstream stalls.
  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      r_out_data <= '0;
      r_out_en   <= 1'b0;
      r_out_last <= 1'b0;
      r_out_keep <= '0;
    end else if (bus.start) begin
      r_out_data <= '0;
      r_out_en   <= 1'b0;
      r_out_last <= 1'b0;
      r_out_keep <= '0;
    end else if (w_beat) begin
      r_out_data <= w_beat_data;
      r_out_en   <= 1'b1;
      r_out_last <= bus.input_last;
      r_out_keep <= w_beat_keep;
    end else if (bus.out_ready) begin
      r_out_en   <= 1'b0;
    end
  end

  assign bus.aes_req   = r_aes_req;
  assign bus.aes_block = {r_flag, r_nonce, r_count};
  assign bus.out_data  = r_out_data;
  assign bus.out_en    = r_out_en;
  assign bus.out_last  = r_out_last;
  assign bus.out_keep  = r_out_keep;
  assign bus.ctr_wrap  = r_wrap;
  assign bus.busy      = (r_state != ST_IDLE);

endmodule
